data_memory_unit: RTL and testbench
===================================

# data_memory_unit

Parametrised, byte-addressed, big-endian data memory with a valid/ready request port, byte-lane write enables, configurable read latency and a hardware clear sequencer that initialises every byte after reset. It sits on the datapath's load/store port. Multi-byte words wrap around the top of the address space.

## Interface

- ADDR_WIDTH, 8: byte address width; DEPTH = 2^ADDR_WIDTH bytes.
- WORD_BYTES, 2: bytes per access; data width W = 8*WORD_BYTES; legal range 1..8.
- READ_LATENCY, 1: cycles from read accept to response; legal range 1..4.
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  byte address of lane 0.
- req_wdata  input  W  write data; bits [W-1:W-8] are lane 0.
- req_be  input  WORD_BYTES  byte-lane write enables; bit WORD_BYTES-1 is lane 0.
- rsp_valid  output  1  one-cycle read-data strobe.
- rsp_rdata  output  W  read data; holds its value between strobes.
- init_busy  output  1  clear sequencer running.

## Operation

- Storage: DEPTH x 8-bit array. Not reset asynchronously; contents are written only by the clear sequencer or accepted writes.
- Lane k maps to byte (req_addr + k) mod DEPTH. Big-endian: lane 0 is the most significant byte.
- States: INIT, READY, RD_WAIT.
- INIT: entered on reset. A counter clears byte c on each edge for c = 0..DEPTH-1, one byte per edge. req_ready=0 and init_busy=1 throughout. Goes to READY after byte DEPTH-1 is cleared. Requests are ignored.
- READY: req_ready=1. A transfer is accepted on an edge where req_valid and req_ready are both 1.
  - Write: lanes with req_be=1 are updated at the accept edge. Lanes with req_be=0 are unchanged. Write produces no response. State stays READY.
  - Read: the word at req_addr is captured at the accept edge. If READ_LATENCY=1, the state stays READY. Otherwise it goes to RD_WAIT.
- RD_WAIT: req_ready=0. A counter tracks READ_LATENCY-1 cycles, then the state returns to READY.
- No read is ever pending while a write is accepted, so read data always equals memory contents at the accept edge.
- Unaccepted requests (req_ready=0) have no effect. The requester must hold them.

## Timing

- Reset values, held while reset_n=0: state INIT, clear counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_busy=1.
- Init: edges 1..DEPTH after reset release clear bytes 0..DEPTH-1. After edge DEPTH, init_busy=0 and req_ready=1.
- Read accepted at edge A:
  - rsp_valid=1 and rsp_rdata is valid for exactly the cycle following edge A+READ_LATENCY-1.
  - For READ_LATENCY=1 this is the cycle right after the accept edge, so back-to-back reads give one response per cycle.
  - For READ_LATENCY=L>1, req_ready is low after edge A and rises after edge A+L-1, in the same cycle as rsp_valid. Throughput is one read per L cycles.
- Write accepted at edge A is visible to a read accepted at edge A+1.
- Wrap-around: access at DEPTH-1 with WORD_BYTES=2 uses bytes DEPTH-1 and 0.
- Reset asserted mid-operation (INIT, RD_WAIT or any cycle):
  - Outputs go to their reset values immediately.
  - A pending read response is dropped.
  - After release, the clear sequence restarts at byte 0.

## Configuration

- DMEM_BOOT_IMAGE_EN defined: during INIT, bytes 0..9 receive the boot image 56 38 00 00 12 43 DE BE EF AD, in address order. All other bytes are cleared. INIT length is unchanged (DEPTH cycles).
- Not defined: every byte is cleared to 0x00.

## Test plan

- Init (defaults, macro off): reset_n low 3 cycles, then release -> init_busy high for exactly 256 cycles, req_ready rises with it falling; read 0x10 -> rsp_rdata 0x0000 one cycle after accept.
- Big-endian write/read: write 0x20 = 0xBEEF, be=11 -> read 0x20 returns 0xBEEF; read 0x21 returns 0xEF00.
- Byte enable: after previous case, write 0x20 = 0x1234, be=01 -> read 0x20 returns 0xBE34.
- Wrap-around: write 0xFF = 0xA55A -> read 0xFF returns 0xA55A; read 0x00 returns 0x5A00.
- Latency, READ_LATENCY=3: req_valid held high for 3 reads -> req_ready low 2 cycles after each accept, rsp_valid pulses every 3 cycles, no lost or duplicated responses.
- Reset mid-read and boot image (macro on, READ_LATENCY=3):
  - Reset asserted 1 cycle after a read accept -> no rsp_valid, full 256-cycle INIT.
  - Then read 0x06 -> 0xDEBE, read 0x08 -> 0xEFAD.

Source files
------------

// File: rtl/data_memory_unit_if.sv
// Request/response bundle for data_memory_unit: valid/ready request channel plus read-data strobe.
// The master modport belongs to the load/store unit and the slave modport to the memory.
interface data_memory_unit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_BYTES = 2
);
    localparam int W = 8 * WORD_BYTES;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [W-1:0]          req_wdata;
    logic [WORD_BYTES-1:0] req_be;
    logic                  rsp_valid;
    logic [W-1:0]          rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/data_memory_unit.sv
// Byte-addressed big-endian data memory with byte enables, configurable read latency and a clear sequencer.
// Define DMEM_BOOT_IMAGE_EN to preload bytes 0..9 with a boot image during the clear sequence.
module data_memory_unit #(
    parameter int ADDR_WIDTH   = 8,
    parameter int WORD_BYTES   = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    data_memory_unit_if.slave  bus,
    output logic               init_busy
);
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int W         = 8 * WORD_BYTES;
    localparam int WAIT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

    typedef enum logic [1:0] {INIT, READY, RD_WAIT} state_t;

    state_t                state;
    state_t                next_state;
    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] rd_src;
    logic [1:0]            wait_cnt;
    logic [7:0]            init_byte;
    logic [W-1:0]          rd_word;
    logic [W-1:0]          rsp_rdata;
    logic                  rsp_valid;
    logic                  ready;
    logic                  accept;
    logic                  init_last;
    logic                  wait_done;

    // Lane k of a word lives at base+k, wrapping at the top of the address space.
    function automatic logic [ADDR_WIDTH-1:0] lane_addr(input logic [ADDR_WIDTH-1:0] base, input int k);
        return base + ADDR_WIDTH'(k);
    endfunction

    assign init_last = (init_cnt == {ADDR_WIDTH{1'b1}});
    assign wait_done = (wait_cnt == 2'(WAIT_LAST));
    assign accept    = bus.req_valid && ready;

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;

    always_comb begin
        init_byte = 8'h00;
`ifdef DMEM_BOOT_IMAGE_EN
        case (32'(init_cnt))
            32'd0:   init_byte = 8'h56;
            32'd1:   init_byte = 8'h38;
            32'd4:   init_byte = 8'h12;
            32'd5:   init_byte = 8'h43;
            32'd6:   init_byte = 8'hDE;
            32'd7:   init_byte = 8'hBE;
            32'd8:   init_byte = 8'hEF;
            32'd9:   init_byte = 8'hAD;
            default: init_byte = 8'h00;
        endcase
`endif
    end

    // While waiting out the latency no write can be accepted, so re-reading the stored address is exact.
    assign rd_src = (state == RD_WAIT) ? rd_addr : bus.req_addr;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            rd_word[W-1-8*k -: 8] = mem[lane_addr(rd_src, k)];
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_cnt] <= init_byte;
        end else if (accept && bus.req_write) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (bus.req_be[WORD_BYTES-1-k]) begin
                    mem[lane_addr(bus.req_addr, k)] <= bus.req_wdata[W-1-8*k -: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        init_busy  = 1'b0;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                if (init_last) begin
                    next_state = READY;
                end
            end
            READY: begin
                ready = 1'b1;
                if (bus.req_valid && !bus.req_write && (READ_LATENCY > 1)) begin
                    next_state = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (wait_done) begin
                    next_state = READY;
                end
            end
            default: next_state = INIT;
        endcase
    end

    // Response strobe is a single cycle; read data is held until the next strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt  <= '0;
            wait_cnt  <= '0;
            rd_addr   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == INIT) begin
                init_cnt <= init_cnt + ADDR_WIDTH'(1);
            end
            if (accept && !bus.req_write) begin
                if (READ_LATENCY == 1) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rd_word;
                end else begin
                    rd_addr  <= bus.req_addr;
                    wait_cnt <= '0;
                end
            end
            if (state == RD_WAIT) begin
                if (wait_done) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rd_word;
                end else begin
                    wait_cnt <= wait_cnt + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: one default instance (latency 1) and one with READ_LATENCY=3.
// Boot-image expectations follow DMEM_BOOT_IMAGE_EN when it is defined for the whole compile.
module tb_data_memory_unit;
    logic clk;
    logic reset_n;
    logic reset_n3;
    logic init_busy1;
    logic init_busy3;
    int   checks;
    int   fails;

    data_memory_unit_if #(.ADDR_WIDTH(8), .WORD_BYTES(2)) bus1 ();
    data_memory_unit_if #(.ADDR_WIDTH(8), .WORD_BYTES(2)) bus3 ();

    data_memory_unit #(.ADDR_WIDTH(8), .WORD_BYTES(2), .READ_LATENCY(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus1.slave),
        .init_busy (init_busy1)
    );

    data_memory_unit #(.ADDR_WIDTH(8), .WORD_BYTES(2), .READ_LATENCY(3)) dut_l3 (
        .clk       (clk),
        .reset_n   (reset_n3),
        .bus       (bus3.slave),
        .init_busy (init_busy3)
    );

`ifdef DMEM_BOOT_IMAGE_EN
    localparam logic [15:0] EXP_WRAP0 = 16'h5A38;
    localparam logic [15:0] EXP_06    = 16'hDEBE;
    localparam logic [15:0] EXP_08    = 16'hEFAD;
`else
    localparam logic [15:0] EXP_WRAP0 = 16'h5A00;
    localparam logic [15:0] EXP_06    = 16'h0000;
    localparam logic [15:0] EXP_08    = 16'h0000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison of the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one request for exactly one clock edge, returning #1 after that edge.
    task automatic applyStimulus(input bit on_l3, input bit write, input logic [7:0] addr,
                                 input logic [15:0] wdata, input logic [1:0] be);
        if (on_l3) begin
            bus3.req_valid = 1'b1; bus3.req_write = write; bus3.req_addr = addr;
            bus3.req_wdata = wdata; bus3.req_be = be;
        end else begin
            bus1.req_valid = 1'b1; bus1.req_write = write; bus1.req_addr = addr;
            bus1.req_wdata = wdata; bus1.req_be = be;
        end
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        bus3.req_valid = 1'b0;
    endtask

    task automatic readCheck(input bit on_l3, input logic [7:0] addr, input logic [15:0] expected, input string tag);
        int n;
        applyStimulus(on_l3, 1'b0, addr, 16'h0000, 2'b00);
        n = 0;
        while (!(on_l3 ? bus3.rsp_valid : bus1.rsp_valid) && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, " latency"}, 64'(n), on_l3 ? 64'd2 : 64'd0);
        checkOutput({tag, " data"}, 64'(on_l3 ? bus3.rsp_rdata : bus1.rsp_rdata), 64'(expected));
    endtask

    task automatic countInit(input bit on_l3, output int n);
        n = 0;
        while ((on_l3 ? init_busy3 : init_busy1) && n < 1000) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int n_acc;
        int n_rsp;
        logic exp_ready;
        logic exp_valid;
        checks = 0;
        fails  = 0;
        reset_n = 1'b0; reset_n3 = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0; bus1.req_be = '0;
        bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0; bus3.req_be = '0;

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset values");
        checkOutput("rst init_busy", 64'(init_busy1), 64'd1);
        checkOutput("rst req_ready", 64'(bus1.req_ready), 64'd0);
        checkOutput("rst rsp_valid", 64'(bus1.rsp_valid), 64'd0);
        checkOutput("rst rsp_rdata", 64'(bus1.rsp_rdata), 64'd0);
        reset_n = 1'b1; reset_n3 = 1'b1;

        countInit(1'b0, n);
        checkOutput("init length", 64'(n), 64'd256);
        checkOutput("init ready", 64'(bus1.req_ready), 64'd1);
        checkOutput("init l3 busy", 64'(init_busy3), 64'd0);
        readCheck(1'b0, 8'h10, 16'h0000, "rd 10 cleared");

        $display("[TB] big-endian, byte enables, wrap");
        applyStimulus(1'b0, 1'b1, 8'h20, 16'hBEEF, 2'b11);
        checkOutput("write no rsp", 64'(bus1.rsp_valid), 64'd0);
        readCheck(1'b0, 8'h20, 16'hBEEF, "rd 20");
        readCheck(1'b0, 8'h21, 16'hEF00, "rd 21");
        applyStimulus(1'b0, 1'b1, 8'h20, 16'h1234, 2'b01);
        readCheck(1'b0, 8'h20, 16'hBE34, "rd 20 be01");
        applyStimulus(1'b0, 1'b1, 8'hFF, 16'hA55A, 2'b11);
        readCheck(1'b0, 8'hFF, 16'hA55A, "rd FF wrap");
        readCheck(1'b0, 8'h00, EXP_WRAP0, "rd 00 wrap");

        $display("[TB] latency 3 throughput");
        applyStimulus(1'b1, 1'b1, 8'h30, 16'h1111, 2'b11);
        applyStimulus(1'b1, 1'b1, 8'h32, 16'h2222, 2'b11);
        applyStimulus(1'b1, 1'b1, 8'h34, 16'h3333, 2'b11);
        checkOutput("l3 ready pre", 64'(bus3.req_ready), 64'd1);
        bus3.req_valid = 1'b1; bus3.req_write = 1'b0; bus3.req_addr = 8'h30;
        n_acc = 0;
        n_rsp = 0;
        for (int i = 0; i < 12; i++) begin
            logic acc;
            acc = bus3.req_ready && bus3.req_valid;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                bus3.req_addr = bus3.req_addr + 8'd2;
                if (n_acc == 3) bus3.req_valid = 1'b0;
            end
            exp_ready = (i % 3 == 2) || (i >= 8);
            exp_valid = (i == 2) || (i == 5) || (i == 8);
            checkOutput($sformatf("l3 ready c%0d", i), 64'(bus3.req_ready), 64'(exp_ready));
            checkOutput($sformatf("l3 rsp_valid c%0d", i), 64'(bus3.rsp_valid), 64'(exp_valid));
            if (bus3.rsp_valid) begin
                n_rsp++;
                checkOutput($sformatf("l3 rdata c%0d", i), 64'(bus3.rsp_rdata), 64'(16'h1111 * n_rsp));
            end
        end
        checkOutput("l3 rsp count", 64'(n_rsp), 64'd3);
        bus3.req_valid = 1'b0;

        $display("[TB] reset during pending read");
        applyStimulus(1'b1, 1'b0, 8'h30, 16'h0000, 2'b00);
        @(posedge clk); #1;
        checkOutput("mid rsp before rst", 64'(bus3.rsp_valid), 64'd0);
        reset_n3 = 1'b0;
        #1;
        checkOutput("mid rst rsp_valid", 64'(bus3.rsp_valid), 64'd0);
        checkOutput("mid rst req_ready", 64'(bus3.req_ready), 64'd0);
        checkOutput("mid rst init_busy", 64'(init_busy3), 64'd1);
        checkOutput("mid rst rsp_rdata", 64'(bus3.rsp_rdata), 64'd0);
        n_rsp = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus3.rsp_valid) n_rsp++;
        end
        reset_n3 = 1'b1;
        countInit(1'b1, n);
        checkOutput("mid dropped rsp", 64'(n_rsp), 64'd0);
        checkOutput("mid init length", 64'(n), 64'd256);
        checkOutput("mid ready", 64'(bus3.req_ready), 64'd1);
        readCheck(1'b1, 8'h30, 16'h0000, "rd 30 recleared");
        readCheck(1'b1, 8'h06, EXP_06, "rd 06 boot");
        readCheck(1'b1, 8'h08, EXP_08, "rd 08 boot");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
